arcade_input_mapper: RTL and testbench

Parametrised player-input front end for arcade cores. It merges PS/2 keyboard events and up to four MiSTer joysticks into per-player, active-low, registered cabinet-input words. It applies display-rotation remapping and opposite-direction (SOCD) cleaning, and generates timed coin pulses. It sits between `hps_io` and the game core's IN0/IN1/DIP-style input ports, replacing ad-hoc per-core key decoding.

---
 rtl/arcade_input_pkg.sv | 153 +++++++++++++++
 rtl/arcade_input_mapper_coin_pulser.sv | 84 ++++++++
 rtl/arcade_input_mapper.sv | 127 ++++++++++++
 tb/tb_arcade_input_mapper.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared types, joystick/scan-code constants and helpers
// for the arcade cabinet input front end.
package arcade_input_pkg;

    typedef enum logic [1:0] {
        ROT_NONE = 2'd0,
        ROT_CW   = 2'd1,
        ROT_180  = 2'd2,
        ROT_CCW  = 2'd3
    } rot_e;

    typedef enum logic [1:0] {
        SOCD_PASS    = 2'd0,
        SOCD_NEUTRAL = 2'd1,
        SOCD_LAST    = 2'd2,
        SOCD_RSVD    = 2'd3
    } socd_e;

    typedef enum logic [1:0] {
        CS_IDLE  = 2'd0,
        CS_PULSE = 2'd1,
        CS_GAP   = 2'd2
    } coin_state_e;

    localparam int JS_RIGHT = 0;
    localparam int JS_LEFT  = 1;
    localparam int JS_DOWN  = 2;
    localparam int JS_UP    = 3;
    localparam int JS_BTN0  = 4;

    localparam logic [8:0] SC_UP0    = 9'h175;
    localparam logic [8:0] SC_DOWN0  = 9'h172;
    localparam logic [8:0] SC_LEFT0  = 9'h16B;
    localparam logic [8:0] SC_RIGHT0 = 9'h174;
    localparam logic [8:0] SC_SPACE  = 9'h029;
    localparam logic [8:0] SC_CTRL   = 9'h014;
    localparam logic [8:0] SC_ALT    = 9'h011;
    localparam logic [8:0] SC_LSHIFT = 9'h012;
    localparam logic [8:0] SC_Z      = 9'h01A;
    localparam logic [8:0] SC_F1     = 9'h005;
    localparam logic [8:0] SC_5      = 9'h02E;
    localparam logic [8:0] SC_R      = 9'h02D;
    localparam logic [8:0] SC_F      = 9'h02B;
    localparam logic [8:0] SC_D      = 9'h023;
    localparam logic [8:0] SC_G      = 9'h034;
    localparam logic [8:0] SC_A      = 9'h01C;
    localparam logic [8:0] SC_S      = 9'h01B;
    localparam logic [8:0] SC_F2     = 9'h006;
    localparam logic [8:0] SC_6      = 9'h036;

    // One latch bit per mapped key
    localparam int K_UP0    = 0;
    localparam int K_DOWN0  = 1;
    localparam int K_LEFT0  = 2;
    localparam int K_RIGHT0 = 3;
    localparam int K_SPACE  = 4;
    localparam int K_CTRL   = 5;
    localparam int K_ALT    = 6;
    localparam int K_LSHIFT = 7;
    localparam int K_Z      = 8;
    localparam int K_START0 = 9;
    localparam int K_COIN0  = 10;
    localparam int K_UP1    = 11;
    localparam int K_DOWN1  = 12;
    localparam int K_LEFT1  = 13;
    localparam int K_RIGHT1 = 14;
    localparam int K_A      = 15;
    localparam int K_S      = 16;
    localparam int K_START1 = 17;
    localparam int K_COIN1  = 18;
    localparam int NKEYS    = 19;

    typedef logic [NKEYS-1:0] keys_t;

    function automatic keys_t key_hit(input logic [8:0] sc);
        keys_t h;
        h = '0;
        case (sc)
            SC_UP0:    h[K_UP0]    = 1'b1;
            SC_DOWN0:  h[K_DOWN0]  = 1'b1;
            SC_LEFT0:  h[K_LEFT0]  = 1'b1;
            SC_RIGHT0: h[K_RIGHT0] = 1'b1;
            SC_SPACE:  h[K_SPACE]  = 1'b1;
            SC_CTRL:   h[K_CTRL]   = 1'b1;
            SC_ALT:    h[K_ALT]    = 1'b1;
            SC_LSHIFT: h[K_LSHIFT] = 1'b1;
            SC_Z:      h[K_Z]      = 1'b1;
            SC_F1:     h[K_START0] = 1'b1;
            SC_5:      h[K_COIN0]  = 1'b1;
            SC_R:      h[K_UP1]    = 1'b1;
            SC_F:      h[K_DOWN1]  = 1'b1;
            SC_D:      h[K_LEFT1]  = 1'b1;
            SC_G:      h[K_RIGHT1] = 1'b1;
            SC_A:      h[K_A]      = 1'b1;
            SC_S:      h[K_S]      = 1'b1;
            SC_F2:     h[K_START1] = 1'b1;
            SC_6:      h[K_COIN1]  = 1'b1;
            default:   h = '0;
        endcase
        return h;
    endfunction

    // Direction vectors are {right, left, down, up}, up at bit 0
    function automatic logic [3:0] kb_dirs(input keys_t k, input int p);
        logic [3:0] d;
        d = '0;
        if (p == 0) d = {k[K_RIGHT0], k[K_LEFT0], k[K_DOWN0], k[K_UP0]};
        if (p == 1) d = {k[K_RIGHT1], k[K_LEFT1], k[K_DOWN1], k[K_UP1]};
        return d;
    endfunction

    function automatic logic kb_btn(input keys_t k, input int p, input int b);
        logic v;
        v = 1'b0;
        if (p == 0) begin
            case (b)
                0:       v = k[K_SPACE] | k[K_CTRL];
                1:       v = k[K_ALT];
                2:       v = k[K_LSHIFT];
                3:       v = k[K_Z];
                default: v = 1'b0;
            endcase
        end else if (p == 1) begin
            case (b)
                0:       v = k[K_A];
                1:       v = k[K_S];
                default: v = 1'b0;
            endcase
        end
        return v;
    endfunction

    function automatic logic kb_start(input keys_t k, input int p);
        return (p == 0) ? k[K_START0] : (p == 1) ? k[K_START1] : 1'b0;
    endfunction

    function automatic logic kb_coin(input keys_t k, input int p);
        return (p == 0) ? k[K_COIN0] : (p == 1) ? k[K_COIN1] : 1'b0;
    endfunction

    function automatic logic [3:0] rotate_dirs(input rot_e rot, input logic [3:0] d);
        logic [3:0] o;
        o = d;
        unique case (rot)
            ROT_NONE: o = d;
            ROT_CW:   o = {d[0], d[1], d[3], d[2]};
            ROT_180:  o = {d[2], d[3], d[0], d[1]};
            ROT_CCW:  o = {d[1], d[0], d[2], d[3]};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// Per-player coin pulse generator: fixed low time, enforced
// high gap, and a single pending request slot.
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int PULSE = 6_000_000,
    parameter int GAP   = 6_000_000
) (
    input  logic clk_sys,
    input  logic RESET_N,
    input  logic req,
    output logic coin_n
);

    localparam int MAXC = (PULSE > GAP) ? PULSE : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    coin_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          req_q;
    logic          rise;

    assign rise = req & ~req_q;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= CS_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            req_q   <= req;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        coin_n  = 1'b1;
        unique case (state_q)
            CS_IDLE: begin
                if (rise) begin
                    state_d = CS_PULSE;
                    cnt_d   = CW'(PULSE - 1);
                end
            end
            CS_PULSE: begin
                coin_n = 1'b0;
                pend_d = pend_q | rise;
                if (cnt_q == '0) begin
                    state_d = CS_GAP;
                    cnt_d   = CW'(GAP - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CS_GAP: begin
                pend_d = pend_q | rise;
                if (cnt_q == '0) begin
                    // A queued request skips IDLE entirely
                    if (pend_q | rise) begin
                        state_d = CS_PULSE;
                        cnt_d   = CW'(PULSE - 1);
                        pend_d  = 1'b0;
                    end else begin
                        state_d = CS_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = CS_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keys and MiSTer joysticks into registered,
// active-low per-player cabinet words with rotation, SOCD and coin.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS       = 2,
    parameter int NUM_BUTTONS       = 1,
    parameter int COIN_PULSE_CYCLES = 6_000_000,
    parameter int COIN_GAP_CYCLES   = 6_000_000
) (
    input  logic                                   clk_sys,
    input  logic                                   RESET_N,
    input  logic [10:0]                            ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]              joystick,
    input  logic [1:0]                             rotate,
    input  logic [1:0]                             socd,
    input  logic                                   coin_from_start,
    output logic [(NUM_BUTTONS+6)*NUM_PLAYERS-1:0] player_n
);

    localparam int W = NUM_BUTTONS + 6;

    logic                       tog_q;
    logic                       armed_q;
    keys_t                      key_q, key_d;
    keys_t                      hit;
    logic                       kb_evt;
    logic [W*NUM_PLAYERS-1:0]   player_n_q, player_n_d;

    // armed_q keeps the first post-reset toggle sample from being an event
    assign kb_evt = armed_q && (ps2_key[10] != tog_q);
    assign hit    = key_hit(ps2_key[8:0]);

    always_comb begin
        key_d = key_q;
        if (kb_evt) key_d = ps2_key[9] ? (key_q | hit) : (key_q & ~hit);
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            tog_q      <= 1'b0;
            armed_q    <= 1'b0;
            key_q      <= '0;
            player_n_q <= '1;
        end else begin
            tog_q      <= ps2_key[10];
            armed_q    <= 1'b1;
            key_q      <= key_d;
            player_n_q <= player_n_d;
        end
    end

    assign player_n = player_n_q;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
        logic [3:0]             dir_m, dir_r, dir_new, dir_c, prev_q;
        logic                   lastv_q, lastv_d, lasth_q, lasth_d;
        logic [NUM_BUTTONS-1:0] btn;
        logic                   start, coin_req, coin_n;

        for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
            assign btn[b] = joystick[16*p + JS_BTN0 + b] | kb_btn(key_q, p, b);
        end

        assign start    = joystick[16*p + JS_BTN0 + NUM_BUTTONS]
                        | kb_start(key_q, p);
        assign coin_req = joystick[16*p + JS_BTN0 + NUM_BUTTONS + 1]
                        | kb_coin(key_q, p)
                        | (coin_from_start & start);

        assign dir_m = {joystick[16*p + JS_RIGHT], joystick[16*p + JS_LEFT],
                        joystick[16*p + JS_DOWN],  joystick[16*p + JS_UP]}
                     | kb_dirs(key_q, p);
        assign dir_r   = rotate_dirs(rot_e'(rotate), dir_m);
        assign dir_new = dir_r & ~prev_q;

        // lastv: 0 up, 1 down; lasth: 0 left, 1 right
        always_comb begin
            lastv_d = lastv_q;
            lasth_d = lasth_q;
            if (dir_new[0] & dir_new[1]) lastv_d = 1'b0;
            else if (dir_new[1])         lastv_d = 1'b1;
            else if (dir_new[0])         lastv_d = 1'b0;
            if (dir_new[2] & dir_new[3]) lasth_d = 1'b0;
            else if (dir_new[3])         lasth_d = 1'b1;
            else if (dir_new[2])         lasth_d = 1'b0;

            dir_c = dir_r;
            unique case (socd_e'(socd))
                SOCD_NEUTRAL: begin
                    if (dir_r[0] & dir_r[1]) dir_c[1:0] = 2'b00;
                    if (dir_r[2] & dir_r[3]) dir_c[3:2] = 2'b00;
                end
                SOCD_LAST: begin
                    if (dir_r[0] & dir_r[1]) dir_c[1:0] = lastv_d ? 2'b10 : 2'b01;
                    if (dir_r[2] & dir_r[3]) dir_c[3:2] = lasth_d ? 2'b10 : 2'b01;
                end
                SOCD_PASS, SOCD_RSVD: dir_c = dir_r;
            endcase
        end

        always_ff @(posedge clk_sys or negedge RESET_N) begin
            if (!RESET_N) begin
                prev_q  <= '0;
                lastv_q <= 1'b0;
                lasth_q <= 1'b0;
            end else begin
                prev_q  <= dir_r;
                lastv_q <= lastv_d;
                lasth_q <= lasth_d;
            end
        end

        coin_pulser #(
            .PULSE (COIN_PULSE_CYCLES),
            .GAP   (COIN_GAP_CYCLES)
        ) u_coin (
            .clk_sys (clk_sys),
            .RESET_N (RESET_N),
            .req     (coin_req),
            .coin_n  (coin_n)
        );

        assign player_n_d[p*W +: W] = {coin_n, ~start, ~btn, ~dir_c};
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench for arcade_input_mapper: two players,
// two buttons, short coin timing.
module tb_arcade_input_mapper;

    localparam int NP = 2;
    localparam int NB = 2;
    localparam int P  = 4;
    localparam int G  = 3;
    localparam int W  = NB + 6;

    localparam logic [3:0]  DU = 4'b0001;
    localparam logic [3:0]  DD = 4'b0010;
    localparam logic [3:0]  DL = 4'b0100;
    localparam logic [3:0]  DR = 4'b1000;
    localparam logic [7:0]  ID8  = 8'hFF;
    localparam logic [15:0] IDLE = 16'hFFFF;

    logic              clk_sys = 1'b0;
    logic              RESET_N;
    logic [10:0]       ps2_key;
    logic [16*NP-1:0]  joystick;
    logic [1:0]        rotate;
    logic [1:0]        socd;
    logic              coin_from_start;
    logic [W*NP-1:0]   player_n;

    arcade_input_mapper #(
        .NUM_PLAYERS       (NP),
        .NUM_BUTTONS       (NB),
        .COIN_PULSE_CYCLES (P),
        .COIN_GAP_CYCLES   (G)
    ) dut (
        .clk_sys         (clk_sys),
        .RESET_N         (RESET_N),
        .ps2_key         (ps2_key),
        .joystick        (joystick),
        .rotate          (rotate),
        .socd            (socd),
        .coin_from_start (coin_from_start),
        .player_n        (player_n)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        int          due;
        logic [15:0] exp;
        bit [95:0]   tag;
    } sb_t;

    sb_t sb[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pw(input logic [3:0] dir, input logic [1:0] btn,
                                      input logic st, input logic cn);
        return ~{cn, st, btn, dir};
    endfunction

    task automatic push(input bit [95:0] tag, input int lat, input logic [15:0] exp);
        sb_t e;
        e.due = cyc + lat;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic kb(input logic [8:0] sc, input logic pr);
        ps2_key = {~ps2_key[10], pr, sc};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk_sys);
            n++;
        end
        if (sb.size() != 0) begin
            chk("sb_drain", sb.size(), 0);
            sb.delete();
        end
    endtask

    always @(negedge clk_sys) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                chk($sformatf("%0s", sb[i].tag), player_n, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RESET_N         = 1'b0;
        joystick        = '1;
        ps2_key         = {1'b1, 1'b1, 9'h175};
        rotate          = 2'd0;
        socd            = 2'd0;
        coin_from_start = 1'b0;
        step(3);
        chk("rst_hold", player_n, IDLE);

        joystick = '0;
        RESET_N  = 1'b1;
        push("no_phantom", 3, IDLE);
        step(4);

        kb(9'h175, 1'b1);
        push("kb_up_l1", 1, IDLE);
        push("kb_up", 2, {ID8, pw(DU, 2'b00, 1'b0, 1'b0)});
        step(3);
        kb(9'h175, 1'b0);
        push("kb_up_rel", 2, IDLE);
        step(3);
        kb(9'h02D, 1'b1);
        push("kb_p1_up", 2, {pw(DU, 2'b00, 1'b0, 1'b0), ID8});
        step(3);
        kb(9'h02D, 1'b0);
        push("kb_p1_rel", 2, IDLE);
        step(3);
        kb(9'h0F0, 1'b1);
        push("kb_unmapped", 2, IDLE);
        step(3);

        rotate   = 2'd1;
        joystick = 32'h0000_0002;
        push("rot1", 1, {ID8, pw(DU, 2'b00, 1'b0, 1'b0)});
        step(2);
        rotate = 2'd3;
        push("rot3", 1, {ID8, pw(DD, 2'b00, 1'b0, 1'b0)});
        step(2);
        rotate = 2'd2;
        push("rot2", 1, {ID8, pw(DR, 2'b00, 1'b0, 1'b0)});
        step(2);
        joystick = 32'h0010_0002;
        push("btn_norot", 1, {pw(4'b0000, 2'b01, 1'b0, 1'b0), pw(DR, 2'b00, 1'b0, 1'b0)});
        step(2);
        rotate   = 2'd0;
        joystick = '0;
        push("rot_idle", 1, IDLE);
        step(2);

        socd     = 2'd2;
        joystick = 32'h0000_0008;
        push("lw_up", 1, {ID8, pw(DU, 2'b00, 1'b0, 1'b0)});
        step(10);
        joystick = 32'h0000_000C;
        push("lw_down", 1, {ID8, pw(DD, 2'b00, 1'b0, 1'b0)});
        step(3);
        joystick = 32'h0000_0008;
        push("lw_back_up", 1, {ID8, pw(DU, 2'b00, 1'b0, 1'b0)});
        step(3);
        joystick = '0;
        step(2);
        joystick = 32'h0000_000C;
        push("lw_simul_v", 1, {ID8, pw(DU, 2'b00, 1'b0, 1'b0)});
        step(2);
        joystick = 32'h0000_0003;
        push("lw_simul_h", 1, {ID8, pw(DL, 2'b00, 1'b0, 1'b0)});
        step(2);
        joystick = 32'h0000_0001;
        step(2);
        joystick = 32'h0000_0003;
        push("lw_h_left", 1, {ID8, pw(DL, 2'b00, 1'b0, 1'b0)});
        step(2);
        socd     = 2'd1;
        joystick = 32'h0000_000C;
        push("neu_v", 1, IDLE);
        step(2);
        joystick = 32'h0000_000F;
        push("neu_hv", 1, IDLE);
        step(2);
        socd = 2'd0;
        push("pass_all", 1, {ID8, pw(4'hF, 2'b00, 1'b0, 1'b0)});
        step(2);
        socd = 2'd3;
        push("rsvd_pass", 1, {ID8, pw(4'hF, 2'b00, 1'b0, 1'b0)});
        step(2);
        socd     = 2'd0;
        joystick = '0;
        push("socd_idle", 1, IDLE);
        drain();

        joystick = 32'h0000_0080;
        for (int i = 1; i <= 20; i++) begin
            logic lo;
            lo = ((i >= 2) && (i <= 1 + P)) || ((i >= 2 + P + G) && (i <= 1 + 2*P + G));
            push("coin_seq", i, {ID8, pw(4'h0, 2'b00, 1'b0, lo)});
        end
        step(1);
        joystick = '0;
        step(1);
        joystick = 32'h0000_0080;
        step(1);
        joystick = '0;
        step(1);
        joystick = 32'h0000_0080;
        step(1);
        joystick = '0;
        drain();
        step(4);

        coin_from_start = 1'b1;
        kb(9'h006, 1'b1);
        push("cfs_l1", 1, IDLE);
        for (int i = 2; i <= 10; i++) begin
            logic lo;
            lo = (i >= 3) && (i <= 2 + P);
            push("cfs_on", i, {pw(4'h0, 2'b00, 1'b1, lo), ID8});
        end
        step(11);
        kb(9'h006, 1'b0);
        push("cfs_rel", 2, IDLE);
        step(10);
        coin_from_start = 1'b0;
        kb(9'h006, 1'b1);
        for (int i = 2; i <= 10; i++) begin
            push("cfs_off", i, {pw(4'h0, 2'b00, 1'b1, 1'b0), ID8});
        end
        step(11);
        kb(9'h006, 1'b0);
        push("cfs_off_rel", 2, IDLE);
        drain();
        step(4);

        joystick = 32'h0000_0080;
        push("rmp_low", 2, {ID8, pw(4'h0, 2'b00, 1'b0, 1'b1)});
        step(3);
        RESET_N = 1'b0;
        #1;
        chk("rst_mid_pulse", player_n, IDLE);
        step(2);
        joystick = '0;
        RESET_N  = 1'b1;
        step(10);
        chk("post_rst_idle", player_n, IDLE);

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
